// File: rtl/vm_credit_ctrl_pkg.sv
// Shared types and defaults for the vending-machine credit controller.
// Widths, coin values and FSM encodings used by the controller and its coin decoder.
package vm_credit_ctrl_pkg;

    localparam int unsigned VM_W      = 5;
    localparam int unsigned VM_PRICE  = 15;
    localparam int unsigned VM_COIN_A = 1;
    localparam int unsigned VM_COIN_B = 5;
    localparam int unsigned VM_COIN_C = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADD      = 3'd1,
        ST_CHECK    = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_REFUND   = 3'd4
    } vm_state_e;

    typedef struct packed {
        logic valid;
        logic illegal;
    } coin_flags_t;

    // Number of coin lines asserted in one cycle.
    function automatic logic [1:0] coin_count(input logic a, input logic b, input logic c);
        return 2'(a) + 2'(b) + 2'(c);
    endfunction

endpackage

// File: rtl/vm_coin_decode.sv
// Combinational coin decoder: one-hot coin pulses to {valid, illegal} flags and coin value.
module vm_coin_decode
    import vm_credit_ctrl_pkg::*;
#(
    parameter int unsigned W      = VM_W,
    parameter int unsigned COIN_A = VM_COIN_A,
    parameter int unsigned COIN_B = VM_COIN_B,
    parameter int unsigned COIN_C = VM_COIN_C
) (
    input  logic         coin_a,
    input  logic         coin_b,
    input  logic         coin_c,
    output coin_flags_t  flags_c,
    output logic [W-1:0] value_c
);

    logic [1:0] count;

    always_comb begin
        flags_c         = '0;
        value_c         = '0;
        count           = coin_count(coin_a, coin_b, coin_c);
        flags_c.valid   = (count == 2'd1);
        flags_c.illegal = (count > 2'd1);
        if (flags_c.valid) begin
            if (coin_a) begin
                value_c = W'(COIN_A);
            end else if (coin_b) begin
                value_c = W'(COIN_B);
            end else begin
                value_c = W'(COIN_C);
            end
        end
    end

endmodule

// File: rtl/vm_credit_ctrl.sv
// Coin-credit controller: accumulates coins through an external add/sub adder,
// dispenses one can when credit reaches PRICE and refunds any remainder.
module vm_credit_ctrl
    import vm_credit_ctrl_pkg::*;
#(
    parameter int unsigned W      = VM_W,
    parameter int unsigned PRICE  = VM_PRICE,
    parameter int unsigned COIN_A = VM_COIN_A,
    parameter int unsigned COIN_B = VM_COIN_B,
    parameter int unsigned COIN_C = VM_COIN_C
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         coin_a,
    input  logic         coin_b,
    input  logic         coin_c,
    input  logic         cancel,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_sub,
    input  logic [W-1:0] add_sum,
    input  logic         add_cout,
    output logic [W-1:0] credit,
    output logic         busy,
    output logic         dispense,
    output logic         change_valid,
    output logic [W-1:0] change_val,
    output logic         coin_reject
);

    vm_state_e    state_q, state_d;
    logic [W-1:0] credit_q, credit_d;
    logic [W-1:0] coin_reg_q, coin_reg_d;
    logic [W-1:0] add_a_q, add_a_d;
    logic [W-1:0] add_b_q, add_b_d;
    logic         add_sub_q, add_sub_d;
    logic         busy_q, busy_d;
    logic         dispense_q, dispense_d;
    logic         change_valid_q, change_valid_d;
    logic [W-1:0] change_val_q, change_val_d;
    logic         coin_reject_q, coin_reject_d;

    coin_flags_t  coin_flags;
    logic [W-1:0] coin_value;
    logic         coin_any;

    vm_coin_decode #(
        .W      (W),
        .COIN_A (COIN_A),
        .COIN_B (COIN_B),
        .COIN_C (COIN_C)
    ) u_coin_decode (
        .coin_a  (coin_a),
        .coin_b  (coin_b),
        .coin_c  (coin_c),
        .flags_c (coin_flags),
        .value_c (coin_value)
    );

    assign coin_any = coin_a | coin_b | coin_c;

    // Next state, credit update and registered-output decode from the next state,
    // so every output (including adder operands) leaves a flop.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reg_d    = coin_reg_q;
        coin_reject_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (coin_flags.illegal) begin
                    coin_reject_d = 1'b1;
                end else if (coin_flags.valid) begin
                    coin_reg_d = coin_value;
                    state_d    = ST_ADD;
                end else if (cancel && (credit_q != '0)) begin
                    state_d = ST_REFUND;
                end
            end
            ST_ADD: begin
                if (add_cout) begin
                    coin_reject_d = 1'b1;
                end else begin
                    credit_d = add_sum;
                end
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (add_cout) begin
                    credit_d = add_sum;
                    state_d  = ST_DISPENSE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DISPENSE: begin
                state_d = (credit_q != '0) ? ST_REFUND : ST_IDLE;
            end
            ST_REFUND: begin
                credit_d = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && coin_any) begin
            coin_reject_d = 1'b1;
        end

        busy_d         = (state_d != ST_IDLE);
        dispense_d     = (state_d == ST_DISPENSE);
        change_valid_d = (state_d == ST_REFUND);
        change_val_d   = (state_d == ST_REFUND) ? credit_d : '0;
        add_a_d        = ((state_d == ST_ADD) || (state_d == ST_CHECK)) ? credit_d : '0;
        add_b_d        = (state_d == ST_ADD)   ? coin_reg_d :
                         (state_d == ST_CHECK) ? W'(PRICE)  : '0;
        add_sub_d      = (state_d == ST_CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            coin_reg_q     <= '0;
            add_a_q        <= '0;
            add_b_q        <= '0;
            add_sub_q      <= 1'b0;
            busy_q         <= 1'b0;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            change_val_q   <= '0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            coin_reg_q     <= coin_reg_d;
            add_a_q        <= add_a_d;
            add_b_q        <= add_b_d;
            add_sub_q      <= add_sub_d;
            busy_q         <= busy_d;
            dispense_q     <= dispense_d;
            change_valid_q <= change_valid_d;
            change_val_q   <= change_val_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    assign add_a        = add_a_q;
    assign add_b        = add_b_q;
    assign add_sub      = add_sub_q;
    assign credit       = credit_q;
    assign busy         = busy_q;
    assign dispense     = dispense_q;
    assign change_valid = change_valid_q;
    assign change_val   = change_val_q;
    assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_vm_credit_ctrl.sv
// Scoreboard bench for vm_credit_ctrl: two instances (PRICE 15 and PRICE 31), each beside
// a behavioural model of the external add/sub adder.
module tb_vm_credit_ctrl;

    localparam int unsigned W = 5;

    typedef struct packed {
        logic         id;
        logic [1:0]   kind;
        logic [W-1:0] val;
        logic [W-1:0] cred;
    } ev_t;

    localparam logic [1:0] K_DISP = 2'd1;
    localparam logic [1:0] K_CHG  = 2'd2;
    localparam logic [1:0] K_REJ  = 2'd3;

    logic clk;
    logic rst_n;
    logic [3:0] in0, in1;

    logic [W-1:0] a0, b0, sum0, cred0, cval0;
    logic         sub0, cout0, busy0, disp0, cv0, rej0;
    logic [W-1:0] a1, b1, sum1, cred1, cval1;
    logic         sub1, cout1, busy1, disp1, cv1, rej1;

    int n_checks;
    int n_fail;
    ev_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign {cout0, sum0} = {1'b0, a0} + {1'b0, b0 ^ {W{sub0}}} + (W+1)'(sub0);
    assign {cout1, sum1} = {1'b0, a1} + {1'b0, b1 ^ {W{sub1}}} + (W+1)'(sub1);

    vm_credit_ctrl #(.W(W), .PRICE(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .coin_a(in0[0]), .coin_b(in0[1]), .coin_c(in0[2]), .cancel(in0[3]),
        .add_a(a0), .add_b(b0), .add_sub(sub0), .add_sum(sum0), .add_cout(cout0),
        .credit(cred0), .busy(busy0), .dispense(disp0),
        .change_valid(cv0), .change_val(cval0), .coin_reject(rej0)
    );

    vm_credit_ctrl #(.W(W), .PRICE(31)) dut31 (
        .clk(clk), .rst_n(rst_n),
        .coin_a(in1[0]), .coin_b(in1[1]), .coin_c(in1[2]), .cancel(in1[3]),
        .add_a(a1), .add_b(b1), .add_sub(sub1), .add_sum(sum1), .add_cout(cout1),
        .credit(cred1), .busy(busy1), .dispense(disp1),
        .change_valid(cv1), .change_val(cval1), .coin_reject(rej1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic observe(input ev_t got);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got 0x%0h, expected none at %0t", got, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event", 32'(got), 32'(e));
        end
    endtask

    task automatic push(input logic id, input logic [1:0] kind, input int val, input int cred);
        ev_t e;
        e.id   = id;
        e.kind = kind;
        e.val  = W'(val);
        e.cred = W'(cred);
        exp_q.push_back(e);
    endtask

    // Monitor: every output pulse pops the next expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rej0)  observe({1'b0, K_REJ,  W'(0), cred0});
            if (disp0) observe({1'b0, K_DISP, W'(0), cred0});
            if (cv0)   observe({1'b0, K_CHG,  cval0, cred0});
            if (rej1)  observe({1'b1, K_REJ,  W'(0), cred1});
            if (disp1) observe({1'b1, K_DISP, W'(0), cred1});
            if (cv1)   observe({1'b1, K_CHG,  cval1, cred1});
        end
    end

    task automatic pulse(input logic id, input logic [3:0] v);
        @(posedge clk); #1;
        if (id) in1 = v; else in0 = v;
        @(posedge clk); #1;
        if (id) in1 = 4'b0; else in0 = 4'b0;
    endtask

    task automatic wait_idle(input logic id);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!(id ? busy1 : busy0)) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: busy still 1, expected 0 within 40 cycles");
        end
    endtask

    task automatic coin(input logic id, input logic [3:0] v);
        pulse(id, v);
        wait_idle(id);
    endtask

    localparam logic [3:0] C_A = 4'b0001;
    localparam logic [3:0] C_B = 4'b0010;
    localparam logic [3:0] C_C = 4'b0100;
    localparam logic [3:0] CAN = 4'b1000;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in0      = 4'b0;
        in1      = 4'b0;
        #12;
        chk("reset_outs0", {a0, b0, sub0, cred0, busy0, disp0, cv0, cval0, rej0}, 32'd0);
        chk("reset_outs1", {a1, b1, sub1, cred1, busy1, disp1, cv1, cval1, rej1}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: 10 + 5 = exactly PRICE, dispense, no change
        coin(1'b0, C_C);
        chk("t1_credit10", 32'(cred0), 32'd10);
        push(1'b0, K_DISP, 0, 0);
        coin(1'b0, C_B);
        chk("t1_credit0", 32'(cred0), 32'd0);

        // 2: 10 + 10 = 20, dispense then change 5
        coin(1'b0, C_C);
        push(1'b0, K_DISP, 0, 5);
        push(1'b0, K_CHG, 5, 5);
        coin(1'b0, C_C);
        chk("t2_credit0", 32'(cred0), 32'd0);

        // 3: 1 x3, cancel refunds 3
        coin(1'b0, C_A);
        coin(1'b0, C_A);
        coin(1'b0, C_A);
        chk("t3_credit3", 32'(cred0), 32'd3);
        push(1'b0, K_CHG, 3, 3);
        coin(1'b0, CAN);
        chk("t3_credit0", 32'(cred0), 32'd0);

        // cancel with zero credit is ignored
        pulse(1'b0, CAN);
        @(negedge clk);
        chk("cancel_zero_busy", 32'(busy0), 32'd0);

        // 4: PRICE 31, credit 30, coin_b overflows and is rejected
        coin(1'b1, C_C);
        coin(1'b1, C_C);
        coin(1'b1, C_C);
        chk("t4_credit30", 32'(cred1), 32'd30);
        push(1'b1, K_REJ, 0, 30);
        coin(1'b1, C_B);
        chk("t4_credit_kept", 32'(cred1), 32'd30);
        push(1'b1, K_CHG, 30, 30);
        coin(1'b1, CAN);
        chk("t4_credit0", 32'(cred1), 32'd0);

        // 5a: two coins together rejected; cancel alongside is dropped
        push(1'b0, K_REJ, 0, 0);
        coin(1'b0, C_B | C_C | CAN);
        @(negedge clk);
        chk("t5_credit0", 32'(cred0), 32'd0);
        chk("t5_idle", 32'(busy0), 32'd0);

        // 5b: coin_a during ADD rejected, credit only gets coin_c
        push(1'b0, K_REJ, 0, 10);
        @(posedge clk); #1;
        in0 = C_C;
        @(posedge clk); #1;
        in0 = C_A;
        @(posedge clk); #1;
        in0 = 4'b0;
        wait_idle(1'b0);
        chk("t5_credit10", 32'(cred0), 32'd10);
        push(1'b0, K_CHG, 10, 10);
        coin(1'b0, CAN);

        // 6: reset during DISPENSE aborts: no change after release
        coin(1'b0, C_C);
        pulse(1'b0, C_C);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_dispense", 32'(disp0), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_outs", {a0, b0, sub0, cred0, busy0, disp0, cv0, cval0, rej0}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_credit0", 32'(cred0), 32'd0);
        chk("t6_idle", 32'(busy0), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
